// File: rtl/host_bridge_pkg.sv
// Shared types and default constants for the host-to-core memory bridge.
package host_bridge_pkg;

    // Job sequencing states; exported on the bridge's o_state debug port.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_DUMP = 3'd3,
        ST_FIN  = 3'd4
    } hb_state_t;

    // Default geometry: 256-byte data memory, 64-byte image in, 64-byte window out.
    localparam int unsigned HB_AW        = 8;
    localparam int unsigned HB_LOAD_BASE = 0;
    localparam int unsigned HB_LOAD_LEN  = 64;
    localparam int unsigned HB_DUMP_BASE = 64;
    localparam int unsigned HB_DUMP_LEN  = 64;
    localparam int unsigned HB_CYC_W     = 16;
    localparam int unsigned HB_MAX_CYC   = (1 << HB_CYC_W) - 1;

endpackage

// File: rtl/byte_out_stage.sv
// One-entry output register for the host dump channel.
//
// Handshake: a byte transfers on a rising edge where o_out_valid && i_out_ready.
// Once o_out_valid is high, o_out_data holds until that transfer happens.
// i_load may be asserted when the entry is empty or is being consumed on the
// same edge; the new byte then replaces it without a bubble.
module byte_out_stage (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_out_ready,
    output logic       o_out_valid,
    output logic [7:0] o_out_data
);

    logic       r_valid;
    logic [7:0] r_data;

    // Fill on load, drain on handshake, otherwise hold the byte steady.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;

endmodule

// File: rtl/host_mem_bridge.sv
// Host-side job sequencer: loads an image into data memory with the core held
// in reset, runs the core until done or timeout, then streams a result window
// back to the host.
module host_mem_bridge
    import host_bridge_pkg::*;
#(
    parameter int unsigned AW        = HB_AW,
    parameter int unsigned LOAD_BASE = HB_LOAD_BASE,
    parameter int unsigned LOAD_LEN  = HB_LOAD_LEN,
    parameter int unsigned DUMP_BASE = HB_DUMP_BASE,
    parameter int unsigned DUMP_LEN  = HB_DUMP_LEN,
    parameter int unsigned CYC_W     = HB_CYC_W,
    parameter int unsigned MAX_CYC   = (1 << CYC_W) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_in_valid,
    input  logic [7:0]       i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [7:0]       o_out_data,
    input  logic             i_out_ready,
    output logic             o_core_reset,
    input  logic             i_core_done,
    output logic             o_mem_sel,
    output logic             o_mem_wr_en,
    output logic [AW-1:0]    o_mem_addr,
    output logic [7:0]       o_mem_wr_data,
    input  logic [7:0]       i_mem_rd_data,
    output logic             o_busy,
    output logic             o_job_done,
    output logic             o_timeout,
    output logic [CYC_W-1:0] o_cycle_count,
    output hb_state_t        o_state
);

    // idx is one bit wider than an address so a full 2^AW-byte window can be counted.
    localparam logic [AW:0]      L_LOAD_LAST = (AW+1)'(LOAD_LEN - 1);
    localparam logic [AW:0]      L_DUMP_LEN  = (AW+1)'(DUMP_LEN);
    localparam logic [AW:0]      L_IDX_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0]    L_LOAD_BASE = AW'(LOAD_BASE);
    localparam logic [AW-1:0]    L_DUMP_BASE = AW'(DUMP_BASE);
    localparam logic [CYC_W-1:0] L_MAX_CYC   = CYC_W'(MAX_CYC);
    localparam logic [CYC_W-1:0] L_CYC_ONE   = CYC_W'(1);

    hb_state_t        r_state;
    logic [AW:0]      r_idx;
    logic [CYC_W-1:0] r_cycle_count;
    logic             r_timeout;
    logic             r_in_ready;
    logic             r_core_reset;
    logic             r_mem_sel;
    logic             r_busy;
    logic             r_job_done;

    logic             w_out_valid;
    logic [7:0]       w_out_data;
    logic             w_out_hs;
    logic             w_stage_load;
    logic [AW:0]      w_idx_inc;
    logic [CYC_W-1:0] w_cyc_inc;

    assign w_idx_inc = r_idx + L_IDX_ONE;
    assign w_cyc_inc = r_cycle_count + L_CYC_ONE;
    assign w_out_hs  = w_out_valid && i_out_ready;

    // Fetch the next dump byte whenever the output entry is free (or freeing)
    // and bytes remain; memory reads are asynchronous so data is ready now.
    assign w_stage_load = (r_state == ST_DUMP) && (r_idx < L_DUMP_LEN) &&
                          (!w_out_valid || i_out_ready);

    // Status flags are registered alongside the state so nothing on them is
    // combinationally reachable from an input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
            r_in_ready    <= 1'b0;
            r_core_reset  <= 1'b1;
            r_mem_sel     <= 1'b1;
            r_busy        <= 1'b0;
            r_job_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_state       <= ST_LOAD;
                        r_idx         <= '0;
                        r_cycle_count <= '0;
                        r_timeout     <= 1'b0;
                        r_job_done    <= 1'b0;
                        r_in_ready    <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (i_in_valid) begin
                        if (r_idx == L_LOAD_LAST) begin
                            r_state      <= ST_RUN;
                            r_idx        <= '0;
                            r_in_ready   <= 1'b0;
                            r_core_reset <= 1'b0;
                            r_mem_sel    <= 1'b0;
                        end else begin
                            r_idx <= w_idx_inc;
                        end
                    end
                end
                ST_RUN: begin
                    r_cycle_count <= w_cyc_inc;
                    // core_done takes priority over a timeout on the same edge.
                    if (i_core_done) begin
                        r_state      <= ST_DUMP;
                        r_core_reset <= 1'b1;
                        r_mem_sel    <= 1'b1;
                    end else if (w_cyc_inc == L_MAX_CYC) begin
                        r_state      <= ST_DUMP;
                        r_core_reset <= 1'b1;
                        r_mem_sel    <= 1'b1;
                        r_timeout    <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (w_stage_load) begin
                        r_idx <= w_idx_inc;
                    end
                    // Once idx has reached DUMP_LEN the only byte left in flight
                    // is the last one, so its handshake ends the job.
                    if (w_out_hs && (r_idx == L_DUMP_LEN)) begin
                        r_state    <= ST_FIN;
                        r_busy     <= 1'b0;
                        r_job_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    byte_out_stage u_out_stage (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_stage_load),
        .i_data      (i_mem_rd_data),
        .i_out_ready (i_out_ready),
        .o_out_valid (w_out_valid),
        .o_out_data  (w_out_data)
    );

    // Memory port: writes only during LOAD, reads address the dump window in DUMP.
    assign o_mem_wr_en   = r_in_ready && i_in_valid;
    assign o_mem_wr_data = i_in_data;
    assign o_mem_addr    = (r_state == ST_DUMP) ? (L_DUMP_BASE + r_idx[AW-1:0])
                                                : (L_LOAD_BASE + r_idx[AW-1:0]);

    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = w_out_valid;
    assign o_out_data    = w_out_data;
    assign o_core_reset  = r_core_reset;
    assign o_mem_sel     = r_mem_sel;
    assign o_busy        = r_busy;
    assign o_job_done    = r_job_done;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_cycle_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_host_mem_bridge.sv
// Bench for host_mem_bridge: two instances share all inputs; A dumps 16 bytes
// from 64, B dumps 10 bytes from 250 so its window wraps through address 0.
module tb_host_mem_bridge;
    import host_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       core_done;

    logic        a_in_ready, a_out_valid, a_core_reset, a_mem_sel, a_mem_wr_en;
    logic        a_busy, a_job_done, a_timeout;
    logic [7:0]  a_out_data, a_mem_addr, a_mem_wr_data, a_mem_rd_data;
    logic [15:0] a_cycle_count;
    hb_state_t   a_state;

    logic        b_in_ready, b_out_valid, b_core_reset, b_mem_sel, b_mem_wr_en;
    logic        b_busy, b_job_done, b_timeout;
    logic [7:0]  b_out_data, b_mem_addr, b_mem_wr_data, b_mem_rd_data;
    logic [15:0] b_cycle_count;
    hb_state_t   b_state;

    host_mem_bridge #(
        .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .DUMP_BASE(64), .DUMP_LEN(16),
        .CYC_W(16), .MAX_CYC(20)
    ) dut_a (
        .clk(clk), .reset(reset), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(a_in_ready),
        .o_out_valid(a_out_valid), .o_out_data(a_out_data), .i_out_ready(out_ready),
        .o_core_reset(a_core_reset), .i_core_done(core_done), .o_mem_sel(a_mem_sel),
        .o_mem_wr_en(a_mem_wr_en), .o_mem_addr(a_mem_addr), .o_mem_wr_data(a_mem_wr_data),
        .i_mem_rd_data(a_mem_rd_data), .o_busy(a_busy), .o_job_done(a_job_done),
        .o_timeout(a_timeout), .o_cycle_count(a_cycle_count), .o_state(a_state)
    );

    host_mem_bridge #(
        .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .DUMP_BASE(250), .DUMP_LEN(10),
        .CYC_W(16), .MAX_CYC(20)
    ) dut_b (
        .clk(clk), .reset(reset), .i_start(start),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(b_in_ready),
        .o_out_valid(b_out_valid), .o_out_data(b_out_data), .i_out_ready(out_ready),
        .o_core_reset(b_core_reset), .i_core_done(core_done), .o_mem_sel(b_mem_sel),
        .o_mem_wr_en(b_mem_wr_en), .o_mem_addr(b_mem_addr), .o_mem_wr_data(b_mem_wr_data),
        .i_mem_rd_data(b_mem_rd_data), .o_busy(b_busy), .o_job_done(b_job_done),
        .o_timeout(b_timeout), .o_cycle_count(b_cycle_count), .o_state(b_state)
    );

    // ---------------- memory models ----------------
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    assign a_mem_rd_data = mem_a[a_mem_addr];
    assign b_mem_rd_data = mem_b[b_mem_addr];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        for (int i = 0; i < 16; i++) mem_a[64 + i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 6; i++) mem_b[250 + i] = 8'hC0 + 8'(i);
        forever begin
            @(posedge clk);
            if (a_mem_sel && a_mem_wr_en) mem_a[a_mem_addr] <= a_mem_wr_data;
            if (b_mem_sel && b_mem_wr_en) mem_b[b_mem_addr] <= b_mem_wr_data;
        end
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  exp_q_a[$];
    logic [7:0]  exp_q_b[$];
    logic [15:0] wr_q_a[$];
    logic [15:0] wr_q_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [15:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got 0x%0h, expected no transfer", name, act);
    endtask

    // Monitors sample at the falling edge, halfway between input changes and edges.
    logic       a_prev_stall = 1'b0, b_prev_stall = 1'b0;
    logic [7:0] a_held = 8'h00, b_held = 8'h00;

    always @(negedge clk) begin
        if (a_prev_stall) check("a_hold", {a_out_valid, a_out_data}, {1'b1, a_held});
        a_prev_stall = a_out_valid && !out_ready && !reset;
        a_held       = a_out_data;
        if (a_out_valid && out_ready) begin
            if (exp_q_a.size() == 0) extra("a_out_extra", {8'h00, a_out_data});
            else check("a_out", a_out_data, exp_q_a.pop_front());
        end
        if (a_mem_sel && a_mem_wr_en) begin
            if (wr_q_a.size() == 0) extra("a_wr_extra", {a_mem_addr, a_mem_wr_data});
            else check("a_wr", {a_mem_addr, a_mem_wr_data}, wr_q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_prev_stall) check("b_hold", {b_out_valid, b_out_data}, {1'b1, b_held});
        b_prev_stall = b_out_valid && !out_ready && !reset;
        b_held       = b_out_data;
        if (b_out_valid && out_ready) begin
            if (exp_q_b.size() == 0) extra("b_out_extra", {8'h00, b_out_data});
            else check("b_out", b_out_data, exp_q_b.pop_front());
        end
        if (b_mem_sel && b_mem_wr_en) begin
            if (wr_q_b.size() == 0) extra("b_wr_extra", {b_mem_addr, b_mem_wr_data});
            else check("b_wr", {b_mem_addr, b_mem_wr_data}, wr_q_b.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic load4(input logic [31:0] bytes, input bit gap);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = bytes[31 - 8*i -: 8];
            wr_q_a.push_back({8'(i), d});
            wr_q_b.push_back({8'(i), d});
            if (gap && i == 1) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = d;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic push_dump(input logic [31:0] loaded);
        for (int i = 0; i < 16; i++) exp_q_a.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < 6; i++) exp_q_b.push_back(8'hC0 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q_b.push_back(loaded[31 - 8*i -: 8]);
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_core_reset"}, a_core_reset, 1);
        check({tag, "_mem_sel"}, a_mem_sel, 1);
        check({tag, "_in_ready"}, a_in_ready, 0);
        check({tag, "_out_valid"}, a_out_valid, 0);
        check({tag, "_out_data"}, a_out_data, 0);
        check({tag, "_mem_wr_en"}, a_mem_wr_en, 0);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_job_done"}, a_job_done, 0);
        check({tag, "_timeout"}, a_timeout, 0);
        check({tag, "_cycle_count"}, a_cycle_count, 0);
        check({tag, "_state"}, a_state, ST_IDLE);
        check({tag, "_b_state"}, b_state, ST_IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; core_done = 1'b0;

        // Reset with start held high: start must not leak through.
        step(); step();
        reset = 1'b0; start = 1'b0;
        check_reset_a("rst");
        step();
        check("rst_start_ignored", a_state, ST_IDLE);

        // Job 1: gapped load, start pulse during RUN, core_done on 10th RUN edge.
        push_dump(32'h11223344);
        pulse_start();
        check("j1_load_state", a_state, ST_LOAD);
        check("j1_in_ready", a_in_ready, 1);
        check("j1_busy", a_busy, 1);
        load4(32'h11223344, 1'b1);
        check("j1_run_state", a_state, ST_RUN);
        check("j1_in_ready_drop", a_in_ready, 0);
        check("j1_core_reset_low", a_core_reset, 0);
        check("j1_mem_sel_core", a_mem_sel, 0);
        for (int k = 1; k <= 9; k++) begin
            start = (k == 5);
            step();
        end
        start = 1'b0;
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("j1_dump_state", a_state, ST_DUMP);
        check("j1_cycle_count", a_cycle_count, 10);
        check("j1_timeout", a_timeout, 0);
        check("j1_core_reset_high", a_core_reset, 1);
        check("j1_first_valid_late", a_out_valid, 0);
        step();
        check("j1_first_valid", a_out_valid, 1);
        check("j1_first_data", a_out_data, 8'hA0);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (a_job_done && b_job_done) break;
            out_ready = ~out_ready;
        end
        check("j1_done", {a_job_done, b_job_done}, 2'b11);
        check("j1_fin_busy", a_busy, 0);
        check("j1_fin_cycle_held", a_cycle_count, 10);
        check("j1_out_left_a", exp_q_a.size(), 0);
        check("j1_out_left_b", exp_q_b.size(), 0);
        check("j1_wr_left", wr_q_a.size() + wr_q_b.size(), 0);
        check("j1_mem3", mem_a[3], 8'h44);
        check("j1_mem4_untouched", mem_a[4], 8'h00);

        // Job 2: restart from FIN, core never finishes -> timeout at 20 cycles.
        out_ready = 1'b1;
        push_dump(32'h55667788);
        pulse_start();
        check("j2_load_state", a_state, ST_LOAD);
        check("j2_cycle_clear", a_cycle_count, 0);
        check("j2_job_done_clear", a_job_done, 0);
        load4(32'h55667788, 1'b0);
        n = 0;
        while (a_state != ST_DUMP && n < 100) begin
            step();
            n++;
        end
        check("j2_run_edges", n, 20);
        check("j2_cycle_count", a_cycle_count, 20);
        check("j2_timeout", a_timeout, 1);
        check("j2_timeout_b", b_timeout, 1);
        n = 0;
        while (!a_job_done && n < 100) begin
            step();
            n++;
        end
        check("j2_dump_edges", n, 17);
        check("j2_done_b", b_job_done, 1);
        check("j2_timeout_held", a_timeout, 1);
        check("j2_out_left", exp_q_a.size() + exp_q_b.size(), 0);

        // Job 3: start from FIN clears timeout; reset while DUMP is stalled.
        out_ready = 1'b0;
        pulse_start();
        check("j3_timeout_clear", a_timeout, 0);
        check("j3_cycle_clear", a_cycle_count, 0);
        load4(32'h01020304, 1'b0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check("j3_dump_state", a_state, ST_DUMP);
        check("j3_cycle_count", a_cycle_count, 1);
        step(); step();
        check("j3_stall_a", {a_out_valid, a_out_data}, {1'b1, 8'hA0});
        check("j3_stall_b", {b_out_valid, b_out_data}, {1'b1, 8'hC0});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_a("mid");
        check("mid_mem_kept", mem_a[0], 8'h01);
        step();
        check("mid_idle_hold", a_state, ST_IDLE);
        check("end_queues", exp_q_a.size() + exp_q_b.size() + wr_q_a.size() + wr_q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
